// File: rtl/uart_apb_arbiter.sv
// Two-requester round-robin arbiter driving a zero-wait-state APB master.
// Each grant runs one APB transfer (SETUP then ACCESS) against the UART
// register slave and reports completion back to the owning requester.
module uart_apb_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        write,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              owner_next;
    logic              last_grant;
    logic              grant;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;

    // Next-state and owner selection; requests are only looked at in IDLE.
    always_comb begin
        state_next = state;
        owner_next = owner;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant      = 1'b1;
                    state_next = SETUP;
                    // On a tie the requester that did not win last time goes next.
                    if (req == 2'b11) begin
                        owner_next = ~last_grant;
                    end else begin
                        owner_next = req[1];
                    end
                end
            end
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration history and the transfer fields captured at grant.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_write  <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner      <= owner_next;
                last_grant <= owner_next;
                lat_addr   <= owner_next ? addr1 : addr0;
                lat_write  <= owner_next ? write[1] : write[0];
                lat_wdata  <= owner_next ? wdata1 : wdata0;
            end
        end
    end

    // Outputs decode the state directly so a reset clears them without a clock.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PADDR   = '0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        done    = 2'b00;
        rdata   = '0;
        busy    = 1'b0;
        if (state == SETUP || state == ACCESS) begin
            PSEL   = 1'b1;
            busy   = 1'b1;
            PADDR  = lat_addr;
            PWRITE = lat_write;
            PWDATA = lat_wdata;
        end
        if (state == ACCESS) begin
            PENABLE     = 1'b1;
            done[owner] = 1'b1;
            if (!lat_write) begin
                rdata = PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Self-checking bench for uart_apb_arbiter: directed scenarios followed by
// random traffic, compared cycle by cycle against a transaction schedule model.
module tb_uart_apb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [1:0]    req;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [1:0]    write;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;

    uart_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (req),
        .addr0   (addr0),
        .addr1   (addr1),
        .write   (write),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
    } xfer_t;

    // Pending transfers per requester; the front entry is what is presented.
    xfer_t q0[$];
    xfer_t q1[$];

    // Schedule model: a grant at edge g puts SETUP after g, ACCESS after g+1,
    // and the next grant can happen no earlier than edge g+3.
    int    edge_n    = 0;
    int    grant_at  = -10;
    int    next_free = 0;
    bit    m_last    = 1'b1;
    bit    m_owner   = 1'b0;
    xfer_t m_x;

    int    errors = 0;
    int    checks = 0;
    bit    fix_prdata = 1'b0;
    bit    obs_grants[$];
    int    done_t[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic refresh();
        req   = {q1.size() != 0, q0.size() != 0};
        addr0 = '0; wdata0 = '0; write[0] = 1'b0;
        addr1 = '0; wdata1 = '0; write[1] = 1'b0;
        if (q0.size() != 0) begin
            addr0 = q0[0].a; write[0] = q0[0].w; wdata0 = q0[0].d;
        end
        if (q1.size() != 0) begin
            addr1 = q1[0].a; write[1] = q1[0].w; wdata1 = q1[0].d;
        end
    endtask

    function automatic logic [127:0] obs_vec();
        return {PSEL, PENABLE, PADDR, PWRITE, PWDATA, done, rdata, busy};
    endfunction

    function automatic logic [127:0] exp_vec();
        int            ph;
        logic          sel, en;
        logic [1:0]    dn;
        logic [DW-1:0] rd;
        ph  = edge_n - grant_at;
        sel = (ph == 0 || ph == 1) && !PRESET;
        en  = (ph == 1) && !PRESET;
        dn  = en ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        rd  = (en && !m_x.w) ? PRDATA : '0;
        return {sel, en, sel ? m_x.a : {AW{1'b0}}, sel & m_x.w,
                sel ? m_x.d : {DW{1'b0}}, dn, rd, sel};
    endfunction

    task automatic model_reset();
        grant_at  = -10;
        next_free = 0;
        m_last    = 1'b1;
    endtask

    // One clock: model decides at the edge, outputs checked 1 ns later,
    // then the requesters react to the completion the model predicted.
    task automatic step();
        @(posedge PCLK);
        edge_n++;
        if (PRESET) begin
            model_reset();
        end else if (edge_n >= next_free && req != 2'b00) begin
            if (req == 2'b01)      m_owner = 1'b0;
            else if (req == 2'b10) m_owner = 1'b1;
            else                   m_owner = ~m_last;
            m_last    = m_owner;
            m_x       = m_owner ? {addr1, write[1], wdata1} : {addr0, write[0], wdata0};
            grant_at  = edge_n;
            next_free = edge_n + 3;
        end
        #1;
        chk("cycle", obs_vec(), exp_vec());
        if (done != 2'b00) begin
            obs_grants.push_back(done == 2'b10);
            done_t.push_back(edge_n);
        end
        if (!PRESET && edge_n == grant_at + 1) begin
            if (m_owner && q1.size() != 0) void'(q1.pop_front());
            if (!m_owner && q0.size() != 0) void'(q0.pop_front());
            refresh();
        end
        if (!fix_prdata) PRDATA = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || edge_n + 1 < next_free) && n < 200) begin
            step();
            n++;
        end
        chk("drain_bound", (n < 200), 1'b1);
        step();
    endtask

    task automatic full_reset();
        PRESET = 1'b1;
        q0.delete(); q1.delete();
        refresh();
        model_reset();
        step();
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1;
        PRDATA = '0;
        refresh();
        #1;
        chk("reset_async", obs_vec(), 128'd0);
        step();
        step();
        PRESET = 1'b0;
        step();

        // Single write from requester 0.
        q0.push_back('{a: 32'h4, w: 1'b1, d: 32'hA5});
        refresh();
        step();
        chk("wr_setup", {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, 1'b0, 32'h4, 32'hA5});
        step();
        chk("wr_access", {PENABLE, done}, {1'b1, 2'b01});
        step();
        chk("wr_idle", obs_vec(), 128'd0);

        // Single read from requester 1 with fixed slave data.
        fix_prdata = 1'b1;
        PRDATA     = 32'h5A;
        q1.push_back('{a: 32'h8, w: 1'b0, d: 32'h0});
        refresh();
        step();
        chk("rd_setup_rdata", rdata, 32'h0);
        step();
        chk("rd_access", {done, rdata}, {2'b10, 32'h5A});
        step();
        chk("rd_after", {done, rdata}, {2'b00, 32'h0});
        fix_prdata = 1'b0;

        // Tie straight after reset: requester 0 first, 3 cycles apart.
        full_reset();
        obs_grants.delete(); done_t.delete();
        q0.push_back('{a: 32'h10, w: 1'b1, d: 32'h11});
        q1.push_back('{a: 32'h20, w: 1'b1, d: 32'h22});
        refresh();
        step();
        chk("tie_paddr", PADDR, 32'h10);
        drain();
        chk("tie_order", {obs_grants.size(), obs_grants[0], obs_grants[1]}, {32'd2, 1'b0, 1'b1});
        chk("tie_spacing", done_t[1] - done_t[0], 3);

        // Fairness with both requesters continuously loaded.
        obs_grants.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{a: 32'h100 + i, w: 1'b1, d: $urandom});
            q1.push_back('{a: 32'h200 + i, w: 1'b0, d: $urandom});
        end
        refresh();
        drain();
        chk("fair_count", obs_grants.size(), 6);
        for (int i = 0; i < 6 && i < obs_grants.size(); i++) begin
            chk("fair_alt", obs_grants[i], i % 2);
        end

        // Inputs disturbed during SETUP must not reach the bus.
        q0.push_back('{a: 32'h30, w: 1'b1, d: 32'h1234});
        refresh();
        step();
        addr0  = 32'hDEAD;
        wdata0 = 32'hBEEF;
        step();
        chk("stable_access", {PADDR, PWDATA}, {32'h30, 32'h1234});
        step();

        // Reset in the middle of SETUP abandons the write.
        q0.push_back('{a: 32'h40, w: 1'b1, d: 32'h77});
        refresh();
        step();
        #2;
        PRESET = 1'b1;
        #1;
        chk("midrst_drop", {PSEL, PENABLE, done, busy}, 5'd0);
        q0.delete();
        refresh();
        model_reset();
        step();
        PRESET = 1'b0;
        done_t.delete();
        q0.push_back('{a: 32'h44, w: 1'b1, d: 32'h88});
        refresh();
        step();
        step();
        chk("midrst_redo", {done, PADDR, PWDATA}, {2'b01, 32'h44, 32'h88});
        step();
        chk("midrst_once", done_t.size(), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                xfer_t x;
                x.a = $urandom;
                x.w = $urandom_range(0, 1);
                x.d = $urandom;
                if ($urandom_range(0, 1) == 0) begin
                    if (q0.size() < 3) q0.push_back(x);
                end else begin
                    if (q1.size() < 3) q1.push_back(x);
                end
                refresh();
            end
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_apb_arbiter.md
UART_APB_ARBITER -- requirements
Module: uart_apb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of requester and APB address buses.
REQ-002 Parameter DATA_W, default 32: data width of requester and APB data buses.
REQ-003 PCLK  input  1  single clock; all state updates on rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester transfer request; bit i belongs to requester i.
REQ-006 addr0, addr1  input  ADDR_W each  per-requester target address.
REQ-007 write  input  2  per-requester direction; 1 = write, 0 = read.
REQ-008 wdata0, wdata1  input  DATA_W each  per-requester write data.
REQ-009 done  output  2  per-requester completion strobe.
REQ-010 rdata  output  DATA_W  read data returned to the completing requester.
REQ-011 busy  output  1  high while a transfer is in SETUP or ACCESS.
REQ-012 PADDR, PWRITE, PSEL, PENABLE, PWDATA  output  ADDR_W/1/1/1/DATA_W  APB master signals to the UART_REG slave.
REQ-013 PRDATA  input  DATA_W  APB read data from the slave.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-015 In IDLE with req != 0, the block SHALL select one owner, latch that owner's addr/write/wdata, and move to SETUP on the next edge.
REQ-016 In IDLE with req == 0, the FSM SHALL remain in IDLE.
REQ-017 SETUP SHALL last exactly 1 cycle with PSEL=1 and PENABLE=0, then move to ACCESS.
REQ-018 ACCESS SHALL last exactly 1 cycle with PSEL=1 and PENABLE=1, then return to IDLE; the slave has no wait states.
REQ-019 PADDR, PWRITE and PWDATA SHALL come from the latched values and stay stable through SETUP and ACCESS.
REQ-020 In IDLE, PSEL, PENABLE, PADDR, PWRITE and PWDATA SHALL all be 0.
REQ-021 done[owner] SHALL be high for exactly the ACCESS cycle; the other done bit SHALL stay 0.
REQ-022 rdata SHALL equal PRDATA while done is high for a read, and SHALL be 0 otherwise.
REQ-023 Each transfer SHALL take 3 cycles minimum (IDLE, SETUP, ACCESS); peak throughput is one transfer per 3 cycles.
REQ-024 req is sampled only in IDLE; changes in req during SETUP or ACCESS SHALL NOT affect the transfer in flight.
REQ-025 A requester SHALL hold req, addr, write and wdata until it sees done, and SHALL drop req on the edge ending done if it has no further transfer.
REQ-026 If exactly one req bit is set in IDLE, that requester SHALL be granted.
REQ-027 If both req bits are set in IDLE, the requester other than the last-granted one SHALL be granted (round-robin).
REQ-028 The 1-bit last-granted register SHALL update on every grant.
REQ-029 A requester holding req continuously SHALL wait at most one other transfer before being granted (no starvation).
REQ-030 busy SHALL be high in SETUP and ACCESS, and low in IDLE.

Reset
REQ-031 While PRESET is high, the FSM SHALL be in IDLE and the last-granted register SHALL be 1, so requester 0 wins the first tie.
REQ-032 While PRESET is high, all latched fields and all outputs SHALL be 0.
REQ-033 Assertion of PRESET SHALL clear PSEL, PENABLE and done immediately, without waiting for a clock edge.
REQ-034 A transfer interrupted by PRESET SHALL be abandoned: no done is issued for it, and it is not retried after reset.
REQ-035 After PRESET deasserts, the first grant SHALL occur on the first edge at which req != 0.

Verification
REQ-036 Single write: req=01, addr0=0x4, write=01, wdata0=0xA5 -> SETUP with PADDR=0x4, PWDATA=0xA5, PSEL=1, PENABLE=0; next cycle PENABLE=1, done=01; then IDLE with all APB outputs 0.
REQ-037 Single read: req=10, addr1=0x8, write=00, PRDATA=0x5A during ACCESS -> done=10 and rdata=0x5A in the ACCESS cycle only.
REQ-038 Tie after reset: req=11 held throughout, each requester dropping req on its done -> requester 0 is served first (addr0 on PADDR), then requester 1; done sequence is 01 then 10, 3 cycles apart.
REQ-039 Fairness: both requesters hold req high for 6 transfers -> grants alternate 0,1,0,1,0,1 and neither requester sees two consecutive grants.
REQ-040 Mid-transfer reset: PRESET pulsed high during SETUP of a write -> PSEL drops before the next edge and no done is asserted; after release, req=01 completes normally in 3 cycles.
REQ-041 Input stability: addr0 and wdata0 changed during SETUP -> PADDR and PWDATA keep the values latched in IDLE through ACCESS.
